evm_result_reader: RTL and testbench
====================================

Name: evm_result_reader

Overview:
- Read-out side of the EVM tally path.
- After polling closes, it steps the 2-bit candidate select through candidates 0..3 and samples the 4-bit count returned for each.
- It computes the winner and a tie flag, then streams a framed 6-byte result record over a valid/ready byte interface to the display/printer/link unit.
- It is the consumer of the select/count-out interface that the vote-recording unit provides.

Parameters:
- CNT_W, 4, width of each candidate count on the count input; legal range 1..6.
- SETTLE_CYCLES, 1, cycles between driving sel and capturing cnt_in; legal range 1..15.
- HEADER, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high; clears all state on the next rising edge of clk.
- start  input  1  single-cycle request to read and report results; sampled only in IDLE.
- sel  output  2  candidate select driven to the count mux.
- cnt_in  input  CNT_W  count returned for the currently selected candidate.
- tx_data  output  8  frame byte.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  downstream accepts the byte on an edge where tx_valid && tx_ready.
- busy  output  1  high from the cycle after start is accepted until the cycle done pulses.
- done  output  1  one-cycle pulse after the final byte is accepted.
- winner  output  2  index of the winning candidate; held until the next frame completes.
- tie  output  1  high if any other candidate equals the maximum count; held like winner.

Behaviour:
- Reset values: sel=0, tx_data=0, tx_valid=0, busy=0, done=0, winner=0, tie=0. Internal count registers, max, index and wait counter are all cleared. Reset asserted mid-frame aborts the frame; the FSM returns to IDLE and tx_valid is 0 after that edge. No partial-frame resume.
- FSM states and transitions:
  - IDLE: on start=1, go to SELECT with index i=0 and max cleared.
  - SELECT: drive sel=i, load the wait counter with SETTLE_CYCLES, go to WAIT.
  - WAIT: decrement the counter each cycle; at 0, go to CAPTURE.
  - CAPTURE: store cnt_in into slot i and update max/winner (rules below). If i==3, go to SEND_HDR; else i=i+1 and go to SELECT.
  - SEND_HDR, SEND_C0..SEND_C3, SEND_RES: present one byte each, advancing only on a tx handshake. After SEND_RES is accepted, go to FIN.
  - FIN: done=1 for one cycle, busy drops, return to IDLE.
- Capture latency: cnt_in is sampled exactly SETTLE_CYCLES+1 cycles after sel changes. sel holds its value through CAPTURE.
- Winner rules:
  - A candidate replaces the current winner only if its count is strictly greater than max, so the lowest index wins among equals.
  - tie=1 if, after all four captures, any non-winner count equals max.
  - All-zero counts give winner=0, tie=1.
  - winner and tie update together in FIN; they are not visible mid-frame.
- Frame, 6 bytes in order:
  - HEADER.
  - Four count bytes, each {id[1:0], 6-bit count zero-extended from CNT_W}.
  - Result byte {tie, 5'b0, winner[1:0]}.
- Handshake:
  - tx_valid goes high in the first SEND state.
  - tx_data and tx_valid are stable while tx_ready=0.
  - On an accepted byte, the next byte is presented on the following cycle with no bubble. tx_valid stays high from header to result byte when tx_ready is held high.
  - tx_valid=0 in IDLE, SELECT, WAIT, CAPTURE and FIN.
- start while busy is ignored (not queued). start coincident with reset is ignored.
- cnt_in changes outside the capture cycle have no effect.
- Counts are captured once per frame; later changes do not alter a frame in progress.
- Minimum frame time with tx_ready tied high is 4*(SETTLE_CYCLES+2)+6+1 cycles from start to done.

Test Plan:
- Counts 3,1,2,0, tx_ready=1, start pulse -> sel steps 0,1,2,3; bytes A5,03,41,82,C0,00; done 19 cycles after start; winner=0, tie=0.
- Counts 5,7,7,2 -> count bytes 05,47,87,C2; result byte 81; winner=1, tie=1.
- All counts 0 -> bytes A5,00,40,80,C0,80; winner=0, tie=1.
- Max count 15 on candidate 3, others 14 -> count byte CF; result 03; no overflow in the compare.
- tx_ready low for 10 cycles on the third byte -> tx_data=41 and tx_valid=1 stable throughout; no byte lost or duplicated; the frame completes once ready returns.
- start re-pulsed during SEND_C1 -> ignored and exactly one frame is emitted. reset during WAIT of candidate 2 -> next edge has busy=0, tx_valid=0, sel=0; a new start gives a complete correct frame.

Source files
------------

// File: rtl/evm_result_reader.sv
// EVM tally read-out: scans the four candidate counts through the select mux,
// picks the winner (lowest index among equals) and streams a 6-byte result frame.
module evm_result_reader #(
    parameter int unsigned CNT_W         = 4,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [7:0]  HEADER        = 8'hA5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [1:0]       sel,
    input  logic [CNT_W-1:0] cnt_in,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             done,
    output logic [1:0]       winner,
    output logic             tie
);

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_SELECT   = 4'd1;
    localparam logic [3:0] ST_WAIT     = 4'd2;
    localparam logic [3:0] ST_CAPTURE  = 4'd3;
    localparam logic [3:0] ST_SEND_HDR = 4'd4;
    localparam logic [3:0] ST_SEND_C0  = 4'd5;
    localparam logic [3:0] ST_SEND_C1  = 4'd6;
    localparam logic [3:0] ST_SEND_C2  = 4'd7;
    localparam logic [3:0] ST_SEND_C3  = 4'd8;
    localparam logic [3:0] ST_SEND_RES = 4'd9;
    localparam logic [3:0] ST_FIN      = 4'd10;

    localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

    logic [3:0]       state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       wait_q, wait_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [1:0]       best_q, best_d;
    logic [1:0]       winner_q, winner_d;
    logic             tie_q, tie_d;

    logic [3:0]       slot_load;
    logic [3:0][7:0]  count_byte;
    logic [3:0]       max_match;
    logic             tie_calc;
    logic [7:0]       result_byte;

    // One capture register per candidate, plus its frame byte and tie contribution.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            logic [CNT_W-1:0] slot_q;

            assign slot_load[gi] = (state_q == ST_CAPTURE) && (idx_q == 2'(gi));

            always_ff @(posedge clk) begin
                if (reset) begin
                    slot_q <= '0;
                end else if (slot_load[gi]) begin
                    slot_q <= cnt_in;
                end
            end

            assign count_byte[gi] = {2'(gi), 6'(slot_q)};
            assign max_match[gi]  = (slot_q == max_q) && (best_q != 2'(gi));
        end
    endgenerate

    assign tie_calc    = |max_match;
    assign result_byte = {tie_calc, 5'b0, best_q};

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wait_d   = wait_q;
        sel_d    = sel_q;
        max_d    = max_q;
        best_d   = best_q;
        winner_d = winner_q;
        tie_d    = tie_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SELECT;
                    idx_d   = 2'd0;
                    max_d   = '0;
                    best_d  = 2'd0;
                end
            end
            ST_SELECT: begin
                sel_d   = idx_q;
                wait_d  = SETTLE;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                wait_d = wait_q - 4'd1;
                if (wait_d == 4'd0) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // Strictly greater keeps the lowest index among equal counts.
                if (cnt_in > max_q) begin
                    max_d  = cnt_in;
                    best_d = idx_q;
                end
                if (idx_q == 2'd3) begin
                    state_d = ST_SEND_HDR;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = ST_SELECT;
                end
            end
            ST_SEND_HDR: if (tx_ready) state_d = ST_SEND_C0;
            ST_SEND_C0:  if (tx_ready) state_d = ST_SEND_C1;
            ST_SEND_C1:  if (tx_ready) state_d = ST_SEND_C2;
            ST_SEND_C2:  if (tx_ready) state_d = ST_SEND_C3;
            ST_SEND_C3:  if (tx_ready) state_d = ST_SEND_RES;
            ST_SEND_RES: if (tx_ready) state_d = ST_FIN;
            ST_FIN: begin
                winner_d = best_q;
                tie_d    = tie_calc;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= 2'd0;
            wait_q   <= 4'd0;
            sel_q    <= 2'd0;
            max_q    <= '0;
            best_q   <= 2'd0;
            winner_q <= 2'd0;
            tie_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wait_q   <= wait_d;
            sel_q    <= sel_d;
            max_q    <= max_d;
            best_q   <= best_d;
            winner_q <= winner_d;
            tie_q    <= tie_d;
        end
    end

    // Frame bytes come from captured registers only, so they hold while stalled.
    always_comb begin
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        case (state_q)
            ST_SEND_HDR: begin tx_data = HEADER;        tx_valid = 1'b1; end
            ST_SEND_C0:  begin tx_data = count_byte[0]; tx_valid = 1'b1; end
            ST_SEND_C1:  begin tx_data = count_byte[1]; tx_valid = 1'b1; end
            ST_SEND_C2:  begin tx_data = count_byte[2]; tx_valid = 1'b1; end
            ST_SEND_C3:  begin tx_data = count_byte[3]; tx_valid = 1'b1; end
            ST_SEND_RES: begin tx_data = result_byte;   tx_valid = 1'b1; end
            default:     begin tx_data = 8'h00;         tx_valid = 1'b0; end
        endcase
    end

    assign sel    = sel_q;
    assign busy   = (state_q != ST_IDLE) && (state_q != ST_FIN);
    assign done   = (state_q == ST_FIN);
    assign winner = winner_q;
    assign tie    = tie_q;

endmodule

// File: tb/tb_evm_result_reader.sv
// Bench for evm_result_reader: directed and random count sets checked against
// a frame model computed straight from the winner/tie rules.
module tb_evm_result_reader;

    localparam int         CNT_W        = 4;
    localparam int         SETTLE       = 1;
    localparam logic [7:0] HDR          = 8'hA5;
    localparam int         FRAME_CYCLES = 4 * (SETTLE + 2) + 6 + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       sel;
    logic [CNT_W-1:0] cnt_in;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             busy;
    logic             done;
    logic [1:0]       winner;
    logic             tie;

    int tests = 0;
    int fails = 0;

    logic [CNT_W-1:0] cnts [4];
    logic [7:0]       exp_q [$];
    logic [7:0]       got_q [$];
    logic [1:0]       sel_seq [$];
    logic [1:0]       exp_w, prev_w;
    logic             exp_t, prev_t;

    always #5 clk = ~clk;

    // Behaves like the recording unit's count mux.
    assign cnt_in = cnts[sel];

    evm_result_reader #(
        .CNT_W(CNT_W), .SETTLE_CYCLES(SETTLE), .HEADER(HDR)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .sel(sel), .cnt_in(cnt_in),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done), .winner(winner), .tie(tie)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic build_expected();
        int mx = 0;
        int n  = 0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) if (int'(cnts[i]) > mx) mx = int'(cnts[i]);
        exp_w = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (int'(cnts[i]) == mx) begin
                exp_w = 2'(i);
                n++;
            end
        end
        exp_t = (n > 1);
        exp_q.push_back(HDR);
        for (int i = 0; i < 4; i++) exp_q.push_back({2'(i), 6'(cnts[i])});
        exp_q.push_back({exp_t, 5'b0, exp_w});
    endtask

    // mode 0: ready held high, 1: random ready, 2: ten-cycle stall on byte 2
    task automatic run_frame(input string name, input int mode, input bit repulse);
        int cycles  = 0;
        int stall   = 0;
        bit done_seen = 0;
        bit pulsed  = 0;
        bit hold_ok = 1;
        bit mid_ok  = 1;
        bit busy_ok = 1;
        build_expected();
        got_q.delete();
        sel_seq.delete();
        @(negedge clk);
        start    = 1'b1;
        tx_ready = 1'b1;
        while (!done_seen && cycles < 1000) begin
            @(negedge clk);
            cycles++;
            start = 1'b0;
            if (repulse && !pulsed && tx_valid && got_q.size() == 2) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
            case (mode)
                1:       tx_ready = 1'($urandom_range(0, 1));
                2:       tx_ready = !(tx_valid && got_q.size() == 2 && stall < 10);
                default: tx_ready = 1'b1;
            endcase
            if (mode == 2 && !tx_ready) begin
                stall++;
                if (tx_valid !== 1'b1 || tx_data !== exp_q[2]) hold_ok = 0;
            end
            if (busy && !tx_valid && cycles > 1 &&
                (sel_seq.size() == 0 || sel_seq[$] !== sel)) sel_seq.push_back(sel);
            if (tx_valid && tx_ready) got_q.push_back(tx_data);
            if (done) begin
                done_seen = 1;
                check({name, " tx_valid in FIN"}, tx_valid, 0);
                check({name, " busy in FIN"}, busy, 0);
            end else begin
                if (winner !== prev_w || tie !== prev_t) mid_ok = 0;
                if (!busy) busy_ok = 0;
            end
        end
        tx_ready = 1'b1;
        check({name, " done seen"}, done_seen, 1);
        if (mode == 0) check({name, " start-to-done cycles"}, cycles, FRAME_CYCLES);
        check({name, " byte count"}, got_q.size(), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("%s byte%0d", name, i),
                  (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hDEAD, exp_q[i]);
        check({name, " sel steps"}, sel_seq.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s sel step%0d", name, i),
                  (i < sel_seq.size()) ? {30'h0, sel_seq[i]} : 32'hDEAD, i);
        check({name, " winner/tie hidden mid-frame"}, mid_ok, 1);
        check({name, " busy through frame"}, busy_ok, 1);
        if (mode == 2) check({name, " stalled byte stable"}, hold_ok, 1);
        @(negedge clk);
        check({name, " winner"}, winner, exp_w);
        check({name, " tie"}, tie, exp_t);
        check({name, " idle busy"}, busy, 0);
        check({name, " idle tx_valid"}, tx_valid, 0);
        $display("[TB] frame %s: counts %0d,%0d,%0d,%0d winner=%0d tie=%0d bytes=%0d",
                 name, cnts[0], cnts[1], cnts[2], cnts[3], winner, tie, got_q.size());
        prev_w = exp_w;
        prev_t = exp_t;
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) cnts[i] = '0;
        prev_w = 2'd0;
        prev_t = 1'b0;
        repeat (3) @(negedge clk);
        check("reset sel", sel, 0);
        check("reset tx_data", tx_data, 0);
        check("reset tx_valid", tx_valid, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset winner", winner, 0);
        check("reset tie", tie, 0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("start with reset ignored", busy, 0);

        cnts = '{4'd3, 4'd1, 4'd2, 4'd0};
        run_frame("basic", 0, 0);
        cnts = '{4'd5, 4'd7, 4'd7, 4'd2};
        run_frame("tie", 0, 0);
        cnts = '{4'd0, 4'd0, 4'd0, 4'd0};
        run_frame("zeros", 0, 0);
        cnts = '{4'd14, 4'd14, 4'd14, 4'd15};
        run_frame("max15", 0, 0);
        cnts = '{4'd3, 4'd1, 4'd2, 4'd0};
        run_frame("stall", 2, 0);
        cnts = '{4'd9, 4'd4, 4'd9, 4'd1};
        run_frame("repulse", 0, 1);

        // Abort a frame while waiting on candidate 2.
        cnts = '{4'd3, 4'd1, 4'd2, 4'd0};
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 50 && sel !== 2'd2; k++) @(negedge clk);
        check("reached candidate 2", sel, 2);
        reset = 1'b1;
        @(negedge clk);
        check("abort busy", busy, 0);
        check("abort tx_valid", tx_valid, 0);
        check("abort sel", sel, 0);
        check("abort done", done, 0);
        check("abort winner", winner, 0);
        check("abort tie", tie, 0);
        reset  = 1'b0;
        prev_w = 2'd0;
        prev_t = 1'b0;
        cnts = '{4'd5, 4'd7, 4'd7, 4'd2};
        run_frame("post-reset", 0, 0);

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 4; i++) cnts[i] = CNT_W'($urandom_range(0, 3));
            if (r % 2 == 1) cnts[$urandom_range(0, 3)] = CNT_W'($urandom_range(0, 15));
            run_frame($sformatf("random%0d", r), (r % 3 == 0) ? 0 : 1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
